// File: rtl/a5_1_stream_xor.sv
// a5_1_stream_xor: packs A5/1 keystream bits into a byte FIFO and XORs them onto a byte stream; A51_KS_TAP_EN adds a push tap.
module a5_1_stream_xor #(
  parameter int KS_FIFO_DEPTH = 4,
  parameter bit MSB_FIRST     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_ok,
  input  logic                             ks,
  input  logic                             in_valid,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [7:0]                       out_data,
  input  logic                             out_ready,
  output logic [$clog2(KS_FIFO_DEPTH):0]   ks_level,
  output logic                             ks_ovf,
  output logic [15:0]                      byte_cnt
`ifdef A51_KS_TAP_EN
  ,
  output logic                             ks_tap_stb,
  output logic [7:0]                       ks_tap_byte
`endif
);
  localparam int AW = $clog2(KS_FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(KS_FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] sr, sr_nx;
  logic [7:0] mem [KS_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pack, push, pop, full, ovf, wr;
  // The IDLE->RUN cycle already carries keystream bit 0, so packing runs in IDLE too.
  always_comb begin
    pack     = init_ok && state != ERR;
    sr_nx    = MSB_FIRST ? {sr[6:0], ks} : {ks, sr[7:1]};
    push     = pack && bit_cnt == 3'd7;
    full     = ks_level == FULL;
    in_ready = state == RUN && ks_level != '0 && (!out_valid || out_ready);
    pop      = in_valid && in_ready;
    ovf      = push && full && !pop;
    wr       = push && !ovf;
    state_nx = !init_ok ? IDLE : ovf ? ERR : state == IDLE ? RUN : state;
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= sr_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ks_level  <= '0;
      ks_ovf    <= 1'b0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      if (!init_ok) begin
        bit_cnt  <= '0;
        sr       <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ks_level <= '0;
        byte_cnt <= '0;
      end else begin
        if (pack) begin
          bit_cnt <= bit_cnt + 3'd1;
          sr      <= sr_nx;
        end
        if (wr) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          byte_cnt <= byte_cnt + 16'd1;
        end
        ks_level <= ks_level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      end
      // The output register survives flushes so a pending result is still delivered.
      if (pop) begin
        out_data  <= in_data ^ mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovf) ks_ovf <= 1'b1;
    end
  end
`ifdef A51_KS_TAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_tap_stb  <= 1'b0;
      ks_tap_byte <= '0;
    end else begin
      ks_tap_stb <= wr;
      if (wr) ks_tap_byte <= sr_nx;
    end
  end
`endif
endmodule

// File: tb/tb_a5_1_stream_xor.sv
// tb_a5_1_stream_xor: table vectors, corner sequences and a randomized queue-model run for a5_1_stream_xor.
module tb_a5_1_stream_xor;
  logic clk = 0, rst, init_ok, ks, in_valid, out_ready;
  logic [7:0] in_data;
  logic in_ready, out_valid, ks_ovf;
  logic [7:0] out_data;
  logic [2:0] ks_level;
  logic [15:0] byte_cnt;
  logic in_ready_l, out_valid_l, ks_ovf_l;
  logic [7:0] out_data_l;
  logic [2:0] ks_level_l;
  logic [15:0] byte_cnt_l;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  a5_1_stream_xor #(.KS_FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .init_ok(init_ok), .ks(ks), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ks_level(ks_level), .ks_ovf(ks_ovf), .byte_cnt(byte_cnt));

  a5_1_stream_xor #(.KS_FIFO_DEPTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .init_ok(init_ok), .ks(ks), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .out_valid(out_valid_l), .out_data(out_data_l), .out_ready(out_ready),
    .ks_level(ks_level_l), .ks_ovf(ks_ovf_l), .byte_cnt(byte_cnt_l));

  typedef struct {
    logic [7:0] pat;
    logic [7:0] din;
    logic [7:0] em;
    logic [7:0] el;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; init_ok = 0; ks = 0; in_valid = 0; in_data = 0; out_ready = 1;
    step();
    rst = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_ks_level"}, ks_level, 0);
    chk({nm, "_ks_ovf"}, ks_ovf, 0);
    chk({nm, "_byte_cnt"}, byte_cnt, 0);
  endtask

  initial begin
    vec_t vt [6];
    logic [7:0] kq [$];
    logic [7:0] tb_bits, kb, od;
    int nb, bc;
    logic ov, er, acc;
    // pat holds the 8 keystream bits in time order, first bit at pat[7]
    vt[0] = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
    vt[1] = '{8'hAA, 8'hAA, 8'h00, 8'hFF};
    vt[2] = '{8'h00, 8'h5C, 8'h5C, 8'h5C};
    vt[3] = '{8'hF0, 8'h00, 8'hF0, 8'h0F};
    vt[4] = '{8'h81, 8'h3C, 8'hBD, 8'hBD};
    vt[5] = '{8'hC4, 8'hFF, 8'h3B, 8'hDC};

    do_reset();
    chk_reset_vals("reset");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      init_ok = 1;
      for (int k = 0; k < 8; k++) begin
        ks = vt[v].pat[7-k];
        #1;
        if (k == 7) chk("tbl_ready_before_byte", in_ready, 0);
        step();
      end
      ks = 0; in_valid = 1; in_data = vt[v].din;
      #1;
      chk("tbl_in_ready", in_ready, 1);
      step();
      in_valid = 0;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_data_msb", out_data, vt[v].em);
      chk("tbl_out_data_lsb", out_data_l, vt[v].el);
      chk("tbl_byte_cnt", byte_cnt, 1);
    end

    // overflow into ERR, then recovery through IDLE
    do_reset();
    init_ok = 1;
    for (int c = 1; c <= 40; c++) begin
      ks = 1'($urandom);
      step();
      if (c == 32) chk("ovf_level32", ks_level, 4);
      if (c == 39) chk("ovf_not_yet", ks_ovf, 0);
    end
    chk("ovf_flag", ks_ovf, 1);
    chk("ovf_in_ready_err", in_ready, 0);
    init_ok = 0;
    step();
    chk("ovf_idle_level", ks_level, 0);
    chk("ovf_sticky", ks_ovf, 1);
    init_ok = 1; ks = 1;
    repeat (8) step();
    chk("ovf_rerun_ready", in_ready, 1);
    chk("ovf_still_sticky", ks_ovf, 1);
    do_reset();
    chk("ovf_cleared_by_rst", ks_ovf, 0);

    // backpressure
    do_reset();
    init_ok = 1; ks = 1;
    repeat (16) step();
    in_valid = 1; in_data = 8'h12; out_ready = 0;
    #1;
    chk("bp_first_ready", in_ready, 1);
    step();
    chk("bp_first_data", out_data, 8'hED);
    in_data = 8'h34;
    #1;
    chk("bp_second_blocked", in_ready, 0);
    step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 8'hED);
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("bp_second_data", out_data, 8'hCB);
    chk("bp_byte_cnt", byte_cnt, 2);
    step();
    chk("bp_drained", out_valid, 0);

    // full FIFO with an accept on the push cycle
    do_reset();
    init_ok = 1; ks = 1;
    for (int c = 1; c <= 39; c++) begin
      step();
      if (c == 32) chk("full_level", ks_level, 4);
    end
    in_valid = 1; in_data = 8'h0F;
    #1;
    chk("full_accept_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("full_level_kept", ks_level, 4);
    chk("full_no_ovf", ks_ovf, 0);
    chk("full_out_data", out_data, 8'hF0);

    // init_ok dropped mid-byte, then rst mid-transfer
    do_reset();
    init_ok = 1; ks = 1;
    repeat (5) step();
    init_ok = 0;
    step();
    chk("mid_flush_level", ks_level, 0);
    init_ok = 1;
    for (int k = 0; k < 8; k++) begin
      ks = 1'(k % 2);
      step();
      if (k == 6) chk("mid_no_early_push", ks_level, 0);
    end
    chk("mid_fresh_push", ks_level, 1);
    in_valid = 1; in_data = 8'h00;
    step();
    chk("mid_out_msb", out_data, 8'h55);
    chk("mid_out_lsb", out_data_l, 8'hAA);
    in_data = 8'h77; out_ready = 0; rst = 1;
    step();
    rst = 0; in_valid = 0;
    chk_reset_vals("rst_mid");

    // randomized run against a queue-level model
    do_reset();
    init_ok = 1;
    kq.delete();
    tb_bits = 0; nb = 0; bc = 0; ov = 0; od = 0;
    for (int c = 0; c < 800; c++) begin
      ks = 1'($urandom);
      in_data = 8'($urandom);
      in_valid = kq.size() >= 3 ? 1'b1 : ($urandom_range(0, 3) != 0);
      out_ready = kq.size() >= 3 ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      er = kq.size() != 0 && (!ov || out_ready);
      chk("rnd_in_ready", in_ready, er);
      acc = in_valid && er;
      step();
      if (acc) begin
        od = in_data ^ kq.pop_front();
        ov = 1;
        bc++;
      end else if (out_ready) ov = 0;
      tb_bits[nb] = ks;
      nb++;
      if (nb == 8) begin
        for (int i = 0; i < 8; i++) kb[7-i] = tb_bits[i];
        kq.push_back(kb);
        nb = 0;
      end
      chk("rnd_out_valid", out_valid, ov);
      if (ov) chk("rnd_out_data", out_data, od);
      chk("rnd_ks_level", ks_level, kq.size());
      chk("rnd_byte_cnt", byte_cnt, bc);
    end
    chk("rnd_no_ovf", ks_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
